// File: rtl/sa_pkg.sv
// Shared definitions for the 8x8 systolic array sequencer: array size,
// drain length, array operation codes and the sequencer state encoding.
package sa_pkg;

    localparam int N            = 8;
    localparam int DRAIN_CYCLES = 16;

    // The PE decodes these values identically.
    localparam logic [2:0] OP_HOLD  = 3'd0;
    localparam logic [2:0] OP_CLEAR = 3'd1;
    localparam logic [2:0] OP_MAC   = 3'd2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/sa_skew.sv
// Triangular delay bank: lane i of the output is lane i of the input
// delayed by exactly i registers (lane 0 passes straight through).
module sa_skew #(
    parameter int WIDTH = 8,
    parameter int N     = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N*WIDTH-1:0] i_data,
    output logic [N*WIDTH-1:0] o_data
);

    for (genvar i = 0; i < N; i++) begin : g_lane
        if (i == 0) begin : g_pass
            assign o_data[WIDTH-1:0] = i_data[WIDTH-1:0];
        end else begin : g_dly
            logic [WIDTH-1:0] r_tap [i];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int s = 0; s < i; s++) begin
                        r_tap[s] <= '0;
                    end
                end else begin
                    r_tap[0] <= i_data[i*WIDTH +: WIDTH];
                    for (int s = 1; s < i; s++) begin
                        r_tap[s] <= r_tap[s-1];
                    end
                end
            end

            assign o_data[i*WIDTH +: WIDTH] = r_tap[i-1];
        end
    end

endmodule

// File: rtl/sa_ctrl.sv
// Job sequencer for the 8x8 systolic array: clear, feed K skewed operand
// rows/columns, drain, signal done. Optional busy-cycle counter: SA_CTRL_PERF_EN.
module sa_ctrl
    import sa_pkg::*;
#(
    parameter int ACT_WIDTH    = 8,
    parameter int WGT_WIDTH    = 8,
    parameter int OP_SIG_WIDTH = 3,
    parameter int K_WIDTH      = 8,
    parameter int ADDR_WIDTH   = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [K_WIDTH-1:0]      k_len,
    output logic                    busy,
    output logic                    done,
    output logic                    result_valid,
    output logic                    act_rd_en,
    output logic [ADDR_WIDTH-1:0]   act_rd_addr,
    input  logic [N*ACT_WIDTH-1:0]  act_rd_data,
    output logic                    wgt_rd_en,
    output logic [ADDR_WIDTH-1:0]   wgt_rd_addr,
    input  logic [N*WGT_WIDTH-1:0]  wgt_rd_data,
    output logic [OP_SIG_WIDTH-1:0] sa_op,
    output logic [N*ACT_WIDTH-1:0]  sa_a,
    output logic [N*WGT_WIDTH-1:0]  sa_w,
    output logic [31:0]             perf_cycles
);

    localparam int DCNT_W = $clog2(DRAIN_CYCLES);

    state_t                  r_state;
    logic [K_WIDTH-1:0]      r_k;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DCNT_W-1:0]       r_drainCnt;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_resultValid;
    logic                    r_rdEn;
    logic                    r_rdVld;
    logic [OP_SIG_WIDTH-1:0] r_op;

    logic [ADDR_WIDTH:0]     w_addrInc;
    logic                    w_lastAddr;
    logic [N*ACT_WIDTH-1:0]  w_actGated;
    logic [N*WGT_WIDTH-1:0]  w_wgtGated;

    // One extra bit so the final-address compare cannot overflow at K max.
    assign w_addrInc  = {1'b0, r_addr} + 1'b1;
    assign w_lastAddr = (w_addrInc == (ADDR_WIDTH+1)'(r_k));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_k           <= '0;
            r_addr        <= '0;
            r_drainCnt    <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_resultValid <= 1'b0;
            r_rdEn        <= 1'b0;
            r_op          <= OP_SIG_WIDTH'(OP_HOLD);
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_k           <= k_len;
                        r_state       <= CLEAR;
                        r_busy        <= 1'b1;
                        r_resultValid <= 1'b0;
                        r_op          <= OP_SIG_WIDTH'(OP_CLEAR);
                    end
                end
                CLEAR: begin
                    if (r_k == '0) begin
                        r_state       <= DONE;
                        r_op          <= OP_SIG_WIDTH'(OP_HOLD);
                        r_done        <= 1'b1;
                        r_resultValid <= 1'b1;
                    end else begin
                        r_state <= FEED;
                        r_op    <= OP_SIG_WIDTH'(OP_MAC);
                        r_rdEn  <= 1'b1;
                        r_addr  <= '0;
                    end
                end
                FEED: begin
                    if (w_lastAddr) begin
                        r_state    <= DRAIN;
                        r_rdEn     <= 1'b0;
                        r_addr     <= '0;
                        r_drainCnt <= '0;
                    end else begin
                        r_addr <= r_addr + 1'b1;
                    end
                end
                DRAIN: begin
                    // Covers memory latency, skew/propagation and the PE register.
                    if (r_drainCnt == DCNT_W'(DRAIN_CYCLES - 1)) begin
                        r_state       <= DONE;
                        r_op          <= OP_SIG_WIDTH'(OP_HOLD);
                        r_done        <= 1'b1;
                        r_resultValid <= 1'b1;
                    end else begin
                        r_drainCnt <= r_drainCnt + 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdVld <= 1'b0;
        end else begin
            r_rdVld <= r_rdEn;
        end
    end

    // Zeros outside the read window keep stale buffer data out of the MACs.
    assign w_actGated = r_rdVld ? act_rd_data : '0;
    assign w_wgtGated = r_rdVld ? wgt_rd_data : '0;

    sa_skew #(
        .WIDTH (ACT_WIDTH),
        .N     (N)
    ) u_actSkew (
        .clk    (clk),
        .reset  (reset),
        .i_data (w_actGated),
        .o_data (sa_a)
    );

    sa_skew #(
        .WIDTH (WGT_WIDTH),
        .N     (N)
    ) u_wgtSkew (
        .clk    (clk),
        .reset  (reset),
        .i_data (w_wgtGated),
        .o_data (sa_w)
    );

`ifdef SA_CTRL_PERF_EN
    logic [31:0] r_perfCnt;
    logic [31:0] r_perfCycles;

    // The DONE cycle itself is busy, hence the +1 when snapshotting.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_perfCnt    <= '0;
            r_perfCycles <= '0;
        end else begin
            if (r_state == IDLE) begin
                if (start) begin
                    r_perfCnt <= '0;
                end
            end else begin
                r_perfCnt <= r_perfCnt + 32'd1;
            end
            if (r_state == DONE) begin
                r_perfCycles <= r_perfCnt + 32'd1;
            end
        end
    end

    assign perf_cycles = r_perfCycles;
`else
    assign perf_cycles = 32'd0;
`endif

    assign busy         = r_busy;
    assign done         = r_done;
    assign result_valid = r_resultValid;
    assign act_rd_en    = r_rdEn;
    assign wgt_rd_en    = r_rdEn;
    assign act_rd_addr  = r_addr;
    assign wgt_rd_addr  = r_addr;
    assign sa_op        = r_op;

endmodule

// File: tb/tb_sa_ctrl.sv
// Directed bench for sa_ctrl with an operand-buffer model and a small
// output-stationary 8x8 array model driven by sa_op/sa_a/sa_w.
module tb_sa_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  k_len;
    logic        busy;
    logic        done;
    logic        result_valid;
    logic        act_rd_en;
    logic [7:0]  act_rd_addr;
    logic [63:0] act_rd_data;
    logic        wgt_rd_en;
    logic [7:0]  wgt_rd_addr;
    logic [63:0] wgt_rd_data;
    logic [2:0]  sa_op;
    logic [63:0] sa_a;
    logic [63:0] sa_w;
    logic [31:0] perf_cycles;

    int checks = 0;
    int errors = 0;
    int doneCnt;
    int doneCyc;
    int expPerf;
    logic rdSeen;
    logic saSeen;

    int         acc  [8][8];
    logic [7:0] aReg [8][8];
    logic [7:0] wReg [8][8];

    sa_ctrl u_dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .k_len        (k_len),
        .busy         (busy),
        .done         (done),
        .result_valid (result_valid),
        .act_rd_en    (act_rd_en),
        .act_rd_addr  (act_rd_addr),
        .act_rd_data  (act_rd_data),
        .wgt_rd_en    (wgt_rd_en),
        .wgt_rd_addr  (wgt_rd_addr),
        .wgt_rd_data  (wgt_rd_data),
        .sa_op        (sa_op),
        .sa_a         (sa_a),
        .sa_w         (sa_w),
        .perf_cycles  (perf_cycles)
    );

    always #5 clk = ~clk;

    // Operand buffers: activation row r holds r+1 in every lane, weights are 1.
    // Junk is returned when not enabled so missing gating shows up in the sums.
    always @(posedge clk) begin
        if (act_rd_en) act_rd_data <= {8{act_rd_addr + 8'd1}};
        else           act_rd_data <= {8{8'h5A}};
        if (wgt_rd_en) wgt_rd_data <= {8{8'h01}};
        else           wgt_rd_data <= {8{8'hA5}};
    end

    // Array model: a flows right, w flows down, each PE accumulates a*w.
    always @(posedge clk) begin
        logic [7:0] aIn;
        logic [7:0] wIn;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                aIn = (j == 0) ? sa_a[i*8 +: 8] : aReg[i][j-1];
                wIn = (i == 0) ? sa_w[j*8 +: 8] : wReg[i-1][j];
                aReg[i][j] <= aIn;
                wReg[i][j] <= wIn;
                if (reset || sa_op == 3'd1)
                    acc[i][j] <= 0;
                else if (sa_op == 3'd2)
                    acc[i][j] <= acc[i][j] + int'(aIn) * int'(wIn);
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic [7:0] k);
        start = s;
        k_len = k;
    endtask

    task automatic checkAcc(input int expected);
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                checkOutput($sformatf("acc[%0d][%0d]", i, j), 64'(acc[i][j]), 64'(expected));
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 8'd0);
        repeat (3) tick();
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_rv", 64'(result_valid), 64'd0);
        checkOutput("rst_op", 64'(sa_op), 64'd0);
        checkOutput("rst_rden", 64'({act_rd_en, wgt_rd_en}), 64'd0);
        checkOutput("rst_sa", 64'(sa_a | sa_w), 64'd0);
        checkOutput("rst_perf", 64'(perf_cycles), 64'd0);
        reset = 1'b0;
        tick();

        $display("[TB] K=4 job");
        applyStimulus(1'b1, 8'd4);
        tick();
        applyStimulus(1'b0, 8'd0);
        doneCnt = 0;
        doneCyc = -1;
        for (int c = 1; c <= 30; c++) begin
            if (c == 1) begin
                checkOutput("clr_op", 64'(sa_op), 64'd1);
                checkOutput("clr_busy", 64'(busy), 64'd1);
                checkOutput("clr_rden", 64'(act_rd_en), 64'd0);
            end
            if (c >= 2 && c <= 5) begin
                checkOutput("feed_en", 64'({act_rd_en, wgt_rd_en}), 64'd3);
                checkOutput("act_addr", 64'(act_rd_addr), 64'(c - 2));
                checkOutput("wgt_addr", 64'(wgt_rd_addr), 64'(c - 2));
                checkOutput("feed_op", 64'(sa_op), 64'd2);
            end
            if (c == 6) checkOutput("feed_end", 64'({act_rd_en, wgt_rd_en}), 64'd0);
            if (c >= 3 && c <= 6) checkOutput("a_lane0", 64'(sa_a[7:0]), 64'(c - 2));
            if (c == 7) checkOutput("a_lane0_gate", 64'(sa_a[7:0]), 64'd0);
            if (c >= 10 && c <= 13) checkOutput("a_lane7", 64'(sa_a[63:56]), 64'(c - 9));
            if (c == 9 || c == 14) checkOutput("a_lane7_gate", 64'(sa_a[63:56]), 64'd0);
            if (c >= 6 && c <= 9) checkOutput("w_lane3", 64'(sa_w[31:24]), 64'd1);
            if (c == 5 || c == 10) checkOutput("w_lane3_gate", 64'(sa_w[31:24]), 64'd0);
            if (c == 21) checkOutput("drain_op", 64'(sa_op), 64'd2);
            if (done) begin
                doneCnt++;
                doneCyc = c;
            end
            if (c == 22) begin
                checkOutput("done_op", 64'(sa_op), 64'd0);
                checkOutput("done_rv", 64'(result_valid), 64'd1);
                checkOutput("done_busy", 64'(busy), 64'd1);
                checkAcc(10);
            end
            tick();
        end
        checkOutput("k4_done_cyc", 64'(doneCyc), 64'd22);
        checkOutput("k4_done_cnt", 64'(doneCnt), 64'd1);
        checkOutput("k4_idle_busy", 64'(busy), 64'd0);
        checkOutput("k4_rv_hold", 64'(result_valid), 64'd1);
`ifdef SA_CTRL_PERF_EN
        expPerf = 22;
`else
        expPerf = 0;
`endif
        checkOutput("k4_perf", 64'(perf_cycles), 64'(expPerf));

        $display("[TB] K=0 job");
        applyStimulus(1'b1, 8'd0);
        tick();
        applyStimulus(1'b0, 8'd0);
        doneCnt = 0;
        doneCyc = -1;
        rdSeen = 1'b0;
        saSeen = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (c == 1) checkOutput("k0_clr_op", 64'(sa_op), 64'd1);
            if (c == 1) checkOutput("k0_rv_drop", 64'(result_valid), 64'd0);
            rdSeen = rdSeen | act_rd_en | wgt_rd_en;
            saSeen = saSeen | (|sa_a) | (|sa_w);
            if (done) begin
                doneCnt++;
                doneCyc = c;
            end
            tick();
        end
        checkOutput("k0_done_cyc", 64'(doneCyc), 64'd2);
        checkOutput("k0_done_cnt", 64'(doneCnt), 64'd1);
        checkOutput("k0_rden", 64'(rdSeen), 64'd0);
        checkOutput("k0_sa", 64'(saSeen), 64'd0);
        checkOutput("k0_acc00", 64'(acc[0][0]), 64'd0);
        checkOutput("k0_acc77", 64'(acc[7][7]), 64'd0);
`ifdef SA_CTRL_PERF_EN
        expPerf = 2;
`else
        expPerf = 0;
`endif
        checkOutput("k0_perf", 64'(perf_cycles), 64'(expPerf));

        $display("[TB] K=6 job with stray starts");
        applyStimulus(1'b1, 8'd6);
        tick();
        applyStimulus(1'b0, 8'd0);
        doneCnt = 0;
        doneCyc = -1;
        for (int c = 1; c <= 40; c++) begin
            if (done) begin
                doneCnt++;
                doneCyc = c;
            end
            if (c == 4 || c == 12) applyStimulus(1'b1, 8'd2);
            else                   applyStimulus(1'b0, 8'd0);
            tick();
        end
        checkOutput("stray_done_cyc", 64'(doneCyc), 64'd24);
        checkOutput("stray_done_cnt", 64'(doneCnt), 64'd1);
        checkOutput("stray_busy", 64'(busy), 64'd0);

        $display("[TB] K=8 job with reset at cycle 6");
        applyStimulus(1'b1, 8'd8);
        tick();
        applyStimulus(1'b0, 8'd0);
        repeat (5) tick();
        checkOutput("pre_rst_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_sa_a", 64'(sa_a), 64'd0);
        checkOutput("abort_sa_w", 64'(sa_w), 64'd0);
        checkOutput("abort_op", 64'(sa_op), 64'd0);
        checkOutput("abort_rden", 64'({act_rd_en, wgt_rd_en}), 64'd0);
        checkOutput("abort_addr", 64'(act_rd_addr), 64'd0);
        checkOutput("abort_rv", 64'(result_valid), 64'd0);
        checkOutput("abort_perf", 64'(perf_cycles), 64'd0);
        doneCnt = 0;
        for (int c = 7; c <= 35; c++) begin
            if (done) doneCnt++;
            tick();
        end
        checkOutput("abort_no_done", 64'(doneCnt), 64'd0);

        $display("[TB] start with reset");
        reset = 1'b1;
        applyStimulus(1'b1, 8'd4);
        tick();
        reset = 1'b0;
        applyStimulus(1'b0, 8'd0);
        checkOutput("rst_wins_busy", 64'(busy), 64'd0);
        checkOutput("rst_wins_op", 64'(sa_op), 64'd0);
        tick();
        checkOutput("rst_wins_idle", 64'(busy), 64'd0);

        $display("[TB] back-to-back K=3 then K=5");
        applyStimulus(1'b1, 8'd3);
        tick();
        applyStimulus(1'b0, 8'd0);
        doneCyc = -1;
        for (int c = 1; c <= 21; c++) begin
            if (done) doneCyc = c;
            if (c == 21) checkAcc(6);
            tick();
        end
        checkOutput("b2b_first_done", 64'(doneCyc), 64'd21);
        checkOutput("b2b_rv_before", 64'(result_valid), 64'd1);
        applyStimulus(1'b1, 8'd5);
        tick();
        applyStimulus(1'b0, 8'd0);
        checkOutput("b2b_rv_drop", 64'(result_valid), 64'd0);
        checkOutput("b2b_busy", 64'(busy), 64'd1);
        doneCnt = 0;
        doneCyc = -1;
        for (int c = 1; c <= 30; c++) begin
            if (done) begin
                doneCnt++;
                doneCyc = c;
            end
            if (c == 23) checkOutput("b2b_acc35", 64'(acc[3][5]), 64'd15);
            tick();
        end
        checkOutput("b2b_second_done", 64'(doneCyc), 64'd23);
        checkOutput("b2b_done_cnt", 64'(doneCnt), 64'd1);
`ifdef SA_CTRL_PERF_EN
        expPerf = 23;
`else
        expPerf = 0;
`endif
        checkOutput("b2b_perf", 64'(perf_cycles), 64'(expPerf));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sa_ctrl.md
# sa_ctrl

Sequencer for the 8x8 systolic array. Accepts a job (reduction length K) over a start handshake, clears the PE accumulators, and streams K activation rows and K weight columns from the operand buffers into the array. Operands are diagonally skewed: row i and column j are delayed i and j cycles respectively. After streaming, the block drains the pipeline, pulses done and flags the array's `out` bus valid. It sits between the operand SRAMs and the array's `a_in`/`w_in`/`operation_signal_in` ports.

## Interface
- ACT_WIDTH, 8, activation lane width
- WGT_WIDTH, 8, weight lane width
- OP_SIG_WIDTH, 3, width of the array operation code
- K_WIDTH, 8, width of the reduction-length field (K max 255)
- ADDR_WIDTH, 8, operand buffer address width (must be >= K_WIDTH)

- clk  in  1  clock; everything is on the rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  job request; accepted only in IDLE
- k_len  in  K_WIDTH  reduction length; sampled with an accepted start
- busy  out  1  high from the cycle after acceptance through DONE
- done  out  1  one-cycle pulse in DONE
- result_valid  out  1  array `out` holds final results; set in DONE, cleared by the next accepted start or by reset
- act_rd_en  out  1  activation buffer read enable
- act_rd_addr  out  ADDR_WIDTH  activation row address
- act_rd_data  in  8*ACT_WIDTH  activation row; valid 1 cycle after act_rd_en
- wgt_rd_en  out  1  weight buffer read enable
- wgt_rd_addr  out  ADDR_WIDTH  weight column-vector address
- wgt_rd_data  in  8*WGT_WIDTH  weight vector; valid 1 cycle after wgt_rd_en
- sa_op  out  OP_SIG_WIDTH  to array operation_signal_in
- sa_a  out  8*ACT_WIDTH  to array a_in; lane i = row i
- sa_w  out  8*WGT_WIDTH  to array w_in; lane j = column j
- perf_cycles  out  32  busy-cycle count of the last job (see Configuration)

## Operation
- FSM states: IDLE, CLEAR, FEED, DRAIN, DONE.
- IDLE: sa_op = OP_HOLD. On start, latch k_len and go to CLEAR. start is ignored in every other state.
- CLEAR: one cycle, sa_op = OP_CLEAR to zero the accumulators. Go to FEED, or to DONE if the latched K is 0.
- FEED: K cycles with sa_op = OP_MAC. Both rd_en are high. Both addresses run 0..K-1 and increment each cycle.
- DRAIN: DRAIN_CYCLES = 16 cycles with sa_op = OP_MAC and rd_en low. The count is 1 cycle of memory latency + 2*7 cycles of skew/propagation + 1 cycle of PE register.
- DONE: one cycle. sa_op = OP_HOLD, done = 1, result_valid set. Then return to IDLE.
- Read-data gating: a valid bit follows rd_en by one cycle. Data entering the skew stage is forced to 0 whenever this bit is low, so the array sees zeros outside the valid window.
- Skew: lane i of sa_a equals gated act data delayed by exactly i registers, so lane 0 has no register. sa_w lane j works the same way with j registers.
- Reset values: state IDLE, every output 0 (sa_op = OP_HOLD = 0), all skew registers 0, address counters 0.
- Reset mid-job aborts immediately. The next cycle is IDLE with all outputs zero. Array contents are undefined and no done pulse is produced.
- Simultaneous start and reset: reset wins.
- Address wrap: none possible, because ADDR_WIDTH >= K_WIDTH.

## Timing
- Start is sampled in IDLE at cycle 0.
- CLEAR is cycle 1.
- FEED covers cycles 2..K+1, with address = cycle - 2.
- Read data for the first address arrives at cycle 3. sa_a lane 0 is valid over cycles 3..K+2 and lane 7 over 10..K+9.
- DRAIN covers cycles K+2..K+17.
- DONE and the done pulse occur at cycle K+18. result_valid is high from cycle K+18.
- For K=0: CLEAR at cycle 1, DONE at cycle 2.
- A new start is accepted at the earliest in the cycle after DONE.

## Configuration
- SA_CTRL_PERF_EN defined: a 32-bit counter increments every busy cycle and is cleared on an accepted start. Its value is copied to perf_cycles in DONE; for example, K=4 gives 22.
- SA_CTRL_PERF_EN undefined: the counter is not built and perf_cycles is tied to 0.

## Structure
- Shared package sa_pkg holds:
  - N = 8 and DRAIN_CYCLES = 16;
  - op codes OP_HOLD = 3'd0, OP_CLEAR = 3'd1, OP_MAC = 3'd2, which the PE decodes identically;
  - the state enum typedef.
- Sub-module sa_skew (parameters WIDTH, N) builds the triangular delay bank. It is instantiated once for activations and once for weights.

## Test plan
- K=4, act row r = all lanes r+1, weights all 1, start at cycle 0:
  - addresses 0..3 on cycles 2..5;
  - sa_a lane 7 equals 1..4 on cycles 10..13;
  - done at cycle 22;
  - every array output equals 10.
- K=0: CLEAR at cycle 1, done at cycle 2, no rd_en ever asserted, all outputs 0.
- Start pulsed during FEED and during DRAIN: ignored; a single done at cycle K+18.
- Reset asserted at cycle 6 of a K=8 job: cycle 7 shows IDLE, busy = 0, sa_a = sa_w = 0, and no done.
- Back-to-back jobs with K=3 then K=5, second start in the cycle after done:
  - result_valid drops on the acceptance;
  - the second done arrives 23 cycles after that start.
- With SA_CTRL_PERF_EN: after a K=4 job, perf_cycles = 22. Without the macro, perf_cycles = 0.
